sv_uart_rx_packer: RTL and testbench
====================================

SV_UART_RX_PACKER -- requirements
Module: sv_uart_rx_packer

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 24, output word width; a multiple of 8 and >= 16.
REQ-002 The module SHALL define localparam WORDS_NUM = DATA_WIDTH/8, the number of bytes per word.
REQ-003 The module SHALL have port iclk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 The module SHALL have port irst, input, 1 bit, reset; one clock; reset is synchronous and active-high.
REQ-005 The module SHALL have port s_axis_tdata, input, 8 bits, received UART byte from the UART engine rx datapath.
REQ-006 The module SHALL have port s_axis_tvalid, input, 1 bit, byte valid.
REQ-007 The module SHALL have port s_axis_tready, output, 1 bit, byte accepted when high with s_axis_tvalid.
REQ-008 The module SHALL have port m_axis_tdata, output, DATA_WIDTH bits, assembled word.
REQ-009 The module SHALL have port m_axis_tvalid, output, 1 bit, word valid.
REQ-010 The module SHALL have port m_axis_tready, input, 1 bit, downstream ready.
REQ-011 The module SHALL have port itimeout, input, 24 bits, inter-byte timeout in iclk cycles; 0 disables timeout.
REQ-012 The module SHALL have port otimeout, output, 1 bit, one-cycle pulse when a partial word is discarded.
REQ-013 The module SHALL have port odrop_cnt, output, 16 bits, count of discarded partial words, saturating at 16'hFFFF.

Function
REQ-014 Bytes SHALL be packed MSB-first: first accepted byte lands in m_axis_tdata[DATA_WIDTH-1:DATA_WIDTH-8], last in [7:0].
REQ-015 Byte counter byte_cnt (0..WORDS_NUM-1) SHALL increment per accepted byte and wrap to 0 on acceptance of byte WORDS_NUM-1.
REQ-016 s_axis_tready SHALL be low only when byte_cnt == WORDS_NUM-1 and m_axis_tvalid is high and m_axis_tready is low; high otherwise (combinational on m_axis_tready).
REQ-017 On acceptance of the last byte in cycle N, the full word SHALL be loaded into the output register and m_axis_tvalid SHALL be high from cycle N+1.
REQ-018 m_axis_tvalid SHALL stay high and m_axis_tdata SHALL stay stable until m_axis_tvalid && m_axis_tready.
REQ-019 Simultaneous output handshake and last-byte acceptance SHALL load the new word with m_axis_tvalid remaining high (back-to-back words, no bubble).
REQ-020 Output handshake without a new word SHALL clear m_axis_tvalid next cycle.
REQ-021 Idle counter SHALL count cycles while byte_cnt != 0 and no byte is accepted, and SHALL clear on any accepted byte or when byte_cnt == 0.
REQ-022 When itimeout != 0 and the idle counter reaches itimeout, the module SHALL clear byte_cnt and the partial shift register, pulse otimeout for exactly one cycle, and increment odrop_cnt (saturating).
REQ-023 A byte accepted in the same cycle the timeout would fire SHALL take priority: byte accepted, no timeout, idle counter cleared.
REQ-024 A timeout SHALL NOT affect a word already held in the output register.
REQ-025 itimeout changing mid-operation SHALL take effect on the next comparison cycle; itimeout == 0 SHALL never fire a timeout.
REQ-026 Partial bytes SHALL never appear on m_axis_tdata; only complete words are presented.

Reset
REQ-027 While irst is high: byte_cnt = 0, idle counter = 0, shift register = 0, m_axis_tdata = 0, m_axis_tvalid = 0, otimeout = 0, odrop_cnt = 0.
REQ-028 Reset asserted mid-word or with a pending output word SHALL discard both without asserting otimeout or changing odrop_cnt from 0.
REQ-029 s_axis_tready SHALL be high in the first cycle after irst deasserts.

Verification (DATA_WIDTH=24)
REQ-030 Bytes 0xA1,0xB2,0xC3 with m_axis_tready=1 -> one word 0xA1B2C3, m_axis_tvalid high one cycle after 0xC3 accepted.
REQ-031 Six bytes 0x01..0x06 back-to-back, m_axis_tready=0 until second word complete -> s_axis_tready low on 0x06 until first word 0x010203 taken, then 0x040506 output with no gap.
REQ-032 itimeout=100, bytes 0x11,0x22 then 100 idle cycles -> otimeout pulse once, odrop_cnt=1; next 0x33,0x44,0x55 -> word 0x334455.
REQ-033 itimeout=100, byte arrives on idle cycle 100 exactly -> no timeout, odrop_cnt unchanged, word completes normally.
REQ-034 itimeout=0, 1 byte then 10000 idle cycles -> no otimeout; two more bytes complete the word.
REQ-035 irst pulsed after 2 bytes and with a pending output word -> all outputs at reset values, next 3 bytes form a fresh word.

Source files
------------

// File: rtl/sv_uart_rx_packer_if.sv
// sv_uart_rx_packer_if: byte-in / word-out stream handshake bundle for the UART rx packer.
interface sv_uart_rx_packer_if #(parameter int DATA_WIDTH = 24);
   logic [7:0]            s_axis_tdata;
   logic                  s_axis_tvalid;
   logic                  s_axis_tready;
   logic [DATA_WIDTH-1:0] m_axis_tdata;
   logic                  m_axis_tvalid;
   logic                  m_axis_tready;
   modport master (
      output s_axis_tdata, s_axis_tvalid, m_axis_tready,
      input  s_axis_tready, m_axis_tdata, m_axis_tvalid
   );
   modport slave (
      input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
      output s_axis_tready, m_axis_tdata, m_axis_tvalid
   );
endinterface

// File: rtl/sv_uart_rx_packer.sv
// sv_uart_rx_packer: packs received UART bytes MSB-first into DATA_WIDTH words,
// discarding stale partial words after a programmable inter-byte timeout.
module sv_uart_rx_packer #(
   parameter int DATA_WIDTH = 24
) (
   input  logic                      iclk,
   input  logic                      irst,
   sv_uart_rx_packer_if.slave        axis,
   input  logic [23:0]               itimeout,
   output logic                      otimeout,
   output logic [15:0]               odrop_cnt
);
   localparam int WORDS_NUM = DATA_WIDTH / 8;
   localparam int CW = $clog2(WORDS_NUM);
   localparam int SW = DATA_WIDTH - 8;
   logic [CW-1:0] byte_cnt;
   logic [SW-1:0] shreg;
   logic [23:0]   idle_cnt;
   logic          last, acc, hs, fire;
   // Timeout fires on the idle cycle that brings the count up to itimeout; a byte in that cycle wins.
   always_comb begin
      last = byte_cnt == CW'(WORDS_NUM - 1);
      axis.s_axis_tready = !(last && axis.m_axis_tvalid && !axis.m_axis_tready);
      acc = axis.s_axis_tvalid && axis.s_axis_tready;
      hs = axis.m_axis_tvalid && axis.m_axis_tready;
      fire = !acc && byte_cnt != '0 && itimeout != '0 && ({1'b0, idle_cnt} + 25'd1 >= {1'b0, itimeout});
   end
   always_ff @(posedge iclk) begin
      if (irst) begin
         byte_cnt <= '0;
         shreg <= '0;
         idle_cnt <= '0;
         axis.m_axis_tdata <= '0;
         axis.m_axis_tvalid <= 1'b0;
         otimeout <= 1'b0;
         odrop_cnt <= '0;
      end else begin
         otimeout <= fire;
         if (acc) begin
            byte_cnt <= last ? '0 : byte_cnt + 1'b1;
            shreg <= last ? '0 : SW'({shreg, axis.s_axis_tdata});
         end else if (fire) begin
            byte_cnt <= '0;
            shreg <= '0;
         end
         idle_cnt <= (acc || fire || byte_cnt == '0) ? '0 : (idle_cnt == '1 ? idle_cnt : idle_cnt + 1'b1);
         if (fire && odrop_cnt != '1) odrop_cnt <= odrop_cnt + 1'b1;
         if (acc && last) begin
            axis.m_axis_tdata <= {shreg, axis.s_axis_tdata};
            axis.m_axis_tvalid <= 1'b1;
         end else if (hs) begin
            axis.m_axis_tvalid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_sv_uart_rx_packer.sv
// tb_sv_uart_rx_packer: directed and randomized checks of the packer against a queue-based reference model.
module tb_sv_uart_rx_packer;
   localparam int WN = 3;
   logic        iclk;
   logic        irst;
   logic [23:0] tmo;
   logic        otimeout;
   logic [15:0] odrop_cnt;
   int          checks, errors;
   logic [7:0]  part[$];
   logic [23:0] got[$];
   int          idle;
   logic        o_valid, o_to;
   logic [23:0] o_data;
   logic [15:0] drops;
   logic        a;
   sv_uart_rx_packer_if #(.DATA_WIDTH(24)) bus ();
   sv_uart_rx_packer #(.DATA_WIDTH(24)) dut (
      .iclk(iclk), .irst(irst), .axis(bus), .itimeout(tmo), .otimeout(otimeout), .odrop_cnt(odrop_cnt)
   );
   initial begin
      iclk = 1'b0;
      forever #5 iclk = ~iclk;
   end
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic step(input logic v, input logic [7:0] d, input logic mr, output logic acc);
      logic exp_rdy, hs;
      logic [23:0] w;
      bus.s_axis_tvalid = v;
      bus.s_axis_tdata = d;
      bus.m_axis_tready = mr;
      #3;
      exp_rdy = !(part.size() == WN - 1 && o_valid && !mr);
      check("s_axis_tready", 32'(bus.s_axis_tready), 32'(exp_rdy));
      check("m_axis_tvalid", 32'(bus.m_axis_tvalid), 32'(o_valid));
      check("m_axis_tdata", 32'(bus.m_axis_tdata), 32'(o_data));
      check("otimeout", 32'(otimeout), 32'(o_to));
      check("odrop_cnt", 32'(odrop_cnt), 32'(drops));
      acc = v && exp_rdy;
      hs = o_valid && mr;
      if (irst) begin
         part.delete();
         idle = 0;
         o_valid = 1'b0;
         o_data = '0;
         o_to = 1'b0;
         drops = '0;
      end else begin
         o_to = 1'b0;
         if (hs) begin
            got.push_back(o_data);
            o_valid = 1'b0;
         end
         if (acc) begin
            part.push_back(d);
            idle = 0;
            if (part.size() == WN) begin
               w = '0;
               foreach (part[i]) w = (w << 8) | 24'(part[i]);
               o_data = w;
               o_valid = 1'b1;
               part.delete();
            end
         end else if (part.size() != 0) begin
            idle++;
            if (tmo != 0 && idle >= int'(tmo)) begin
               part.delete();
               idle = 0;
               o_to = 1'b1;
               if (drops != 16'hFFFF) drops++;
            end
         end else begin
            idle = 0;
         end
      end
      @(posedge iclk);
      #1;
   endtask
   task automatic send(input logic [7:0] d, input logic mr);
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) step(1'b1, d, mr, ok);
      check("send_accepted", 32'(ok), 32'(1));
   endtask
   task automatic idle_steps(input int n, input logic mr);
      logic x;
      for (int k = 0; k < n; k++) step(1'b0, 8'h00, mr, x);
   endtask
   task automatic expect_word(input string tag, input logic [23:0] w);
      logic [23:0] g;
      g = got.size() != 0 ? got.pop_front() : 24'hxxxxxx;
      check(tag, 32'(g), 32'(w));
   endtask
   initial begin
      checks = 0;
      errors = 0;
      idle = 0;
      o_valid = 1'b0;
      o_to = 1'b0;
      o_data = '0;
      drops = '0;
      tmo = '0;
      irst = 1'b1;
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tdata = '0;
      bus.m_axis_tready = 1'b0;
      repeat (2) @(posedge iclk);
      #1;
      irst = 1'b0;
      idle_steps(1, 1'b1);
      send(8'hA1, 1'b1);
      send(8'hB2, 1'b1);
      send(8'hC3, 1'b1);
      idle_steps(2, 1'b1);
      expect_word("word_a1b2c3", 24'hA1B2C3);
      for (int b = 1; b <= 5; b++) send(8'(b), 1'b0);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 8'h06, 1'b0, a);
         check("byte6_stalled", 32'(a), 32'(0));
      end
      send(8'h06, 1'b1);
      check("no_bubble_valid", 32'(bus.m_axis_tvalid), 32'(1));
      idle_steps(2, 1'b1);
      expect_word("word_010203", 24'h010203);
      expect_word("word_040506", 24'h040506);
      tmo = 24'd100;
      send(8'h11, 1'b1);
      send(8'h22, 1'b1);
      idle_steps(100, 1'b1);
      check("timeout_pulse", 32'(otimeout), 32'(1));
      check("drop_after_timeout", 32'(odrop_cnt), 32'(1));
      idle_steps(1, 1'b1);
      send(8'h33, 1'b1);
      send(8'h44, 1'b1);
      send(8'h55, 1'b1);
      idle_steps(2, 1'b1);
      expect_word("word_334455", 24'h334455);
      send(8'h66, 1'b1);
      send(8'h77, 1'b1);
      idle_steps(99, 1'b1);
      send(8'h88, 1'b1);
      idle_steps(2, 1'b1);
      check("drop_unchanged", 32'(odrop_cnt), 32'(1));
      expect_word("word_667788", 24'h667788);
      tmo = 24'd0;
      send(8'h99, 1'b1);
      idle_steps(10000, 1'b1);
      send(8'hAA, 1'b1);
      send(8'hBB, 1'b1);
      idle_steps(2, 1'b1);
      check("drop_tmo0", 32'(odrop_cnt), 32'(1));
      expect_word("word_99aabb", 24'h99AABB);
      send(8'hC1, 1'b0);
      send(8'hC2, 1'b0);
      send(8'hC3, 1'b0);
      send(8'hD1, 1'b0);
      send(8'hD2, 1'b0);
      irst = 1'b1;
      idle_steps(1, 1'b0);
      irst = 1'b0;
      check("rst_tvalid", 32'(bus.m_axis_tvalid), 32'(0));
      check("rst_tdata", 32'(bus.m_axis_tdata), 32'(0));
      check("rst_drop", 32'(odrop_cnt), 32'(0));
      check("rst_tready", 32'(bus.s_axis_tready), 32'(1));
      send(8'hE1, 1'b1);
      send(8'hE2, 1'b1);
      send(8'hE3, 1'b1);
      idle_steps(2, 1'b1);
      expect_word("word_e1e2e3", 24'hE1E2E3);
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 99) == 0) tmo = 24'($urandom_range(0, 3) * 4);
         irst = $urandom_range(0, 499) == 0;
         step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 3) != 0, a);
      end
      irst = 1'b0;
      idle_steps(3, 1'b1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
